ogr_job_sequencer: RTL and testbench

OGR_JOB_SEQUENCER -- requirements
Module: ogr_job_sequencer

---
 rtl/ogr_job_sequencer_pkg.sv | 32 +++
 rtl/ogr_result_mux.sv | 27 ++
 rtl/ogr_job_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ogr_job_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ogr_job_sequencer_pkg.sv
// +-----------------------------------------------------------------------+
// | ogr_job_sequencer_pkg : shared sizes, state encoding and helpers      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package ogr_job_sequencer_pkg;

  localparam int NUMPOSITIONS = 5;
  localparam int PVW          = 8;
  localparam int NRS          = 5;
  localparam int W            = (NUMPOSITIONS + 1) * PVW;
  localparam int WDOG_W       = 22;
  localparam int HOLD_W       = 3;
  localparam int IDX_W        = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_STATUS = 3'd4
  } state_e;

  // The engine may report more hits than it has slots to hold.
  function automatic logic [IDX_W-1:0] clip_count(input logic [IDX_W-1:0] n, input int lim);
    return (n > IDX_W'(lim)) ? IDX_W'(lim) : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ogr_result_mux.sv
// +-----------------------------------------------------------------------+
// | ogr_result_mux : picks 1-based result slot; slot 1 is the MSB word    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module ogr_result_mux #(
  parameter int W   = 48,
  parameter int NRS = 5
) (
  input  logic [W*NRS-1:0] slots,
  input  logic [5:0]       sel,
  output logic [W-1:0]     marks
);

  always_comb begin
    marks = '0;
    for (int k = 1; k <= NRS; k++) begin
      if (sel == 6'(k)) begin
        marks = slots[W*(NRS-k) +: W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ogr_job_sequencer.sv
// +-----------------------------------------------------------------------+
// | ogr_job_sequencer : feeds jobs to a search engine, drains its results |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module ogr_job_sequencer #(
  parameter int NUMPOSITIONS   = ogr_job_sequencer_pkg::NUMPOSITIONS,
  parameter int PVW            = ogr_job_sequencer_pkg::PVW,
  parameter int NRS            = ogr_job_sequencer_pkg::NRS,
  parameter int RESET_HOLD     = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int W             = (NUMPOSITIONS + 1) * PVW
) (
  input  logic             FXCLK,
  input  logic             RESET_IN,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [W-1:0]     job_firstvalues,
  output logic             eng_reset,
  output logic [W-1:0]     eng_firstvalues,
  input  logic             eng_done,
  input  logic [5:0]       eng_num_results,
  input  logic [W*NRS-1:0] eng_results,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_marks,
  output logic [5:0]       res_index,
  output logic             res_last,
  output logic             stat_valid,
  output logic             stat_timeout,
  output logic [5:0]       stat_count,
  output logic             busy
);

  import ogr_job_sequencer_pkg::*;

  state_e              state;
  state_e              state_nx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WDOG_W-1:0]   wdog;
  logic [IDX_W-1:0]    count;
  logic                tmo_flag;
  logic [W*NRS-1:0]    snap;

  logic [IDX_W-1:0]    w_clip;
  logic                w_hold_done;
  logic                w_wdog_exp;
  logic [W*NRS-1:0]    w_mux_src;
  logic [5:0]          w_mux_sel;
  logic [W-1:0]        w_mux_out;

  assign w_clip      = clip_count(eng_num_results, NRS);
  assign w_hold_done = (hold_cnt == HOLD_W'(RESET_HOLD - 1));
  assign w_wdog_exp  = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // On the done cycle the snapshot is not yet written, so slot 1 comes straight from the engine.
  assign w_mux_src = (state == S_RUN) ? eng_results : snap;
  assign w_mux_sel = (state == S_RUN) ? 6'd1 : (res_index + 6'd1);

  ogr_result_mux #(
    .W   (W),
    .NRS (NRS)
  ) u_result_mux (
    .slots (w_mux_src),
    .sel   (w_mux_sel),
    .marks (w_mux_out)
  );

  assign job_ready  = (state == S_IDLE);
  assign eng_reset  = (state != S_RUN);
  assign res_valid  = (state == S_DRAIN);
  assign stat_valid = (state == S_STATUS);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge FXCLK) begin
    if (!RESET_IN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (job_valid) state_nx = S_LOAD;
      S_LOAD:   if (w_hold_done) state_nx = S_RUN;
      S_RUN: begin
        if (eng_done) begin
          state_nx = (w_clip != '0) ? S_DRAIN : S_STATUS;
        end else if (w_wdog_exp) begin
          state_nx = S_STATUS;
        end
      end
      S_DRAIN:  if (res_ready && res_last) state_nx = S_STATUS;
      S_STATUS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge FXCLK) begin
    if (!RESET_IN) begin
      eng_firstvalues <= '0;
      hold_cnt        <= '0;
      wdog            <= '0;
      count           <= '0;
      tmo_flag        <= 1'b0;
      snap            <= '0;
      res_marks       <= '0;
      res_index       <= '0;
      res_last        <= 1'b0;
      stat_timeout    <= 1'b0;
      stat_count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            eng_firstvalues <= job_firstvalues;
            hold_cnt        <= '0;
            wdog            <= '0;
            count           <= '0;
            tmo_flag        <= 1'b0;
          end
        end
        S_LOAD: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          wdog     <= '0;
        end
        S_RUN: begin
          wdog <= wdog + WDOG_W'(1);
          if (eng_done) begin
            snap  <= eng_results;
            count <= w_clip;
            if (w_clip != '0) begin
              res_index <= 6'd1;
              res_marks <= w_mux_out;
              res_last  <= (w_clip == 6'd1);
            end else begin
              stat_count   <= '0;
              stat_timeout <= 1'b0;
            end
          end else if (w_wdog_exp) begin
            tmo_flag     <= 1'b1;
            count        <= '0;
            stat_count   <= '0;
            stat_timeout <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (res_last) begin
              stat_count   <= count;
              stat_timeout <= tmo_flag;
            end else begin
              res_index <= res_index + 6'd1;
              res_marks <= w_mux_out;
              res_last  <= ((res_index + 6'd1) == count);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ogr_job_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_ogr_job_sequencer : directed self-checking bench                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_ogr_job_sequencer;

  localparam int W   = 48;
  localparam int NRS = 5;
  localparam int RH  = 4;
  localparam int TO  = 100;

  logic             FXCLK = 1'b0;
  logic             RESET_IN;
  logic             job_valid;
  logic             job_ready;
  logic [W-1:0]     job_firstvalues;
  logic             eng_reset;
  logic [W-1:0]     eng_firstvalues;
  logic             eng_done;
  logic [5:0]       eng_num_results;
  logic [W*NRS-1:0] eng_results;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_marks;
  logic [5:0]       res_index;
  logic             res_last;
  logic             stat_valid;
  logic             stat_timeout;
  logic [5:0]       stat_count;
  logic             busy;

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] JOB_A = 48'h000102030405;
  localparam logic [W-1:0] JOB_B = 48'h00020507090C;
  localparam logic [W-1:0] R1    = 48'h0001040A0C11;
  localparam logic [W-1:0] R2    = 48'h0001040A0F11;

  logic [W*NRS-1:0] res2;
  logic [W*NRS-1:0] res5;

  ogr_job_sequencer #(
    .NUMPOSITIONS   (5),
    .PVW            (8),
    .NRS            (NRS),
    .RESET_HOLD     (RH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .FXCLK           (FXCLK),
    .RESET_IN        (RESET_IN),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_firstvalues (job_firstvalues),
    .eng_reset       (eng_reset),
    .eng_firstvalues (eng_firstvalues),
    .eng_done        (eng_done),
    .eng_num_results (eng_num_results),
    .eng_results     (eng_results),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_marks       (res_marks),
    .res_index       (res_index),
    .res_last        (res_last),
    .stat_valid      (stat_valid),
    .stat_timeout    (stat_timeout),
    .stat_count      (stat_count),
    .busy            (busy)
  );

  always #5 FXCLK = ~FXCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_job_ready"},    64'(job_ready),       64'd1);
    chk({p, "_eng_reset"},    64'(eng_reset),       64'd1);
    chk({p, "_eng_fv"},       64'(eng_firstvalues), 64'd0);
    chk({p, "_res_valid"},    64'(res_valid),       64'd0);
    chk({p, "_res_marks"},    64'(res_marks),       64'd0);
    chk({p, "_res_index"},    64'(res_index),       64'd0);
    chk({p, "_res_last"},     64'(res_last),        64'd0);
    chk({p, "_stat_valid"},   64'(stat_valid),      64'd0);
    chk({p, "_stat_timeout"}, 64'(stat_timeout),    64'd0);
    chk({p, "_stat_count"},   64'(stat_count),      64'd0);
    chk({p, "_busy"},         64'(busy),            64'd0);
  endtask

  // Count LOAD cycles from the negedge right after acceptance until RUN.
  task automatic wait_run();
    int n;
    n = 0;
    while (eng_reset && n < 20) begin
      n++;
      @(negedge FXCLK);
    end
    chk("load_len", 64'(n), 64'(RH));
  endtask

  task automatic start_job(input logic [W-1:0] fv);
    job_valid       = 1'b1;
    job_firstvalues = fv;
    @(negedge FXCLK);
    job_valid = 1'b0;
    wait_run();
  endtask

  // Called on the first RUN negedge; raises eng_done during RUN cycle number 'cycles'.
  task automatic run_done(input int cycles, input logic [5:0] num, input logic [W*NRS-1:0] r);
    repeat (cycles - 1) @(negedge FXCLK);
    chk("run_before_done", 64'(eng_reset), 64'd0);
    eng_done        = 1'b1;
    eng_num_results = num;
    eng_results     = r;
    @(negedge FXCLK);
    eng_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    res2 = {R1, R2, {3{48'h0}}};
    res5 = {48'd1, 48'd2, 48'd3, 48'd4, 48'd5};
    RESET_IN        = 1'b0;
    job_valid       = 1'b0;
    job_firstvalues = '0;
    eng_done        = 1'b0;
    eng_num_results = '0;
    eng_results     = '0;
    res_ready       = 1'b1;

    repeat (2) @(negedge FXCLK);
    check_reset_vals("por");
    RESET_IN = 1'b1;
    @(negedge FXCLK);

    // Two results, consumer always ready
    start_job(JOB_A);
    chk("t1_eng_fv", 64'(eng_firstvalues), 64'(JOB_A));
    chk("t1_busy",   64'(busy),            64'd1);
    chk("t1_jready", 64'(job_ready),       64'd0);
    run_done(50, 6'd2, res2);
    chk("t1_rv1",    64'(res_valid), 64'd1);
    chk("t1_idx1",   64'(res_index), 64'd1);
    chk("t1_marks1", 64'(res_marks), 64'(R1));
    chk("t1_last1",  64'(res_last),  64'd0);
    chk("t1_ereset", 64'(eng_reset), 64'd1);
    @(negedge FXCLK);
    chk("t1_idx2",   64'(res_index), 64'd2);
    chk("t1_marks2", 64'(res_marks), 64'(R2));
    chk("t1_last2",  64'(res_last),  64'd1);
    @(negedge FXCLK);
    chk("t1_sv",     64'(stat_valid),   64'd1);
    chk("t1_rv_off", 64'(res_valid),    64'd0);
    chk("t1_scount", 64'(stat_count),   64'd2);
    chk("t1_stmo",   64'(stat_timeout), 64'd0);
    @(negedge FXCLK);
    chk("t1_sv_off", 64'(stat_valid), 64'd0);
    chk("t1_idle",   64'(job_ready),  64'd1);
    chk("t1_hold",   64'(stat_count), 64'd2);

    // Done with zero results
    start_job(JOB_B);
    run_done(10, 6'd0, '0);
    chk("t2_sv",     64'(stat_valid),   64'd1);
    chk("t2_rv",     64'(res_valid),    64'd0);
    chk("t2_scount", 64'(stat_count),   64'd0);
    chk("t2_stmo",   64'(stat_timeout), 64'd0);
    @(negedge FXCLK);
    chk("t2_busy",   64'(busy), 64'd0);

    // Watchdog: engine never finishes
    start_job(JOB_A);
    n = 0;
    while (!stat_valid && n < 300) begin
      @(negedge FXCLK);
      n++;
    end
    chk("t3_latency", 64'(n),            64'(TO));
    chk("t3_stmo",    64'(stat_timeout), 64'd1);
    chk("t3_scount",  64'(stat_count),   64'd0);
    chk("t3_ereset",  64'(eng_reset),    64'd1);
    @(negedge FXCLK);
    chk("t3_ereset2", 64'(eng_reset),  64'd1);
    chk("t3_idle",    64'(job_ready),  64'd1);
    chk("t3_sv_off",  64'(stat_valid), 64'd0);

    // Engine over-reports: only NRS slots are delivered
    start_job(JOB_B);
    run_done(5, 6'd9, res5);
    for (int k = 1; k <= NRS; k++) begin
      chk("t4_rv",    64'(res_valid), 64'd1);
      chk("t4_idx",   64'(res_index), 64'(k));
      chk("t4_marks", 64'(res_marks), 64'(k));
      chk("t4_last",  64'(res_last),  64'(k == NRS));
      @(negedge FXCLK);
    end
    chk("t4_sv",     64'(stat_valid), 64'd1);
    chk("t4_scount", 64'(stat_count), 64'd5);
    @(negedge FXCLK);

    // Back-pressure on result 2 and a job offered during DRAIN
    start_job(JOB_A);
    run_done(3, 6'd2, res2);
    job_valid       = 1'b1;
    job_firstvalues = JOB_B;
    @(negedge FXCLK);
    res_ready = 1'b0;
    chk("t5_idx2", 64'(res_index), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge FXCLK);
      chk("t5_stall_rv",    64'(res_valid), 64'd1);
      chk("t5_stall_idx",   64'(res_index), 64'd2);
      chk("t5_stall_marks", 64'(res_marks), 64'(R2));
      chk("t5_stall_last",  64'(res_last),  64'd1);
      chk("t5_stall_jrdy",  64'(job_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge FXCLK);
    chk("t5_sv",     64'(stat_valid), 64'd1);
    chk("t5_scount", 64'(stat_count), 64'd2);
    chk("t5_jrdy_s", 64'(job_ready),  64'd0);
    @(negedge FXCLK);
    chk("t5_jrdy_i", 64'(job_ready), 64'd1);
    @(negedge FXCLK);
    job_valid = 1'b0;
    chk("t5_eng_fv", 64'(eng_firstvalues), 64'(JOB_B));
    chk("t5_busy",   64'(busy),            64'd1);
    wait_run();

    // Reset in the middle of DRAIN
    run_done(3, 6'd2, res2);
    res_ready = 1'b0;
    chk("t6_rv", 64'(res_valid), 64'd1);
    RESET_IN = 1'b0;
    @(negedge FXCLK);
    check_reset_vals("mid");
    RESET_IN  = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge FXCLK);
      chk("t6_no_sv", 64'(stat_valid), 64'd0);
      chk("t6_idle",  64'(busy),       64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
